// File: rtl/not16_resp_checker.sv
// not16_resp_checker
// Self-checking consumer for a 16-bit NOT gate. It accepts {stimulus,
// response} pairs over a valid/ready stream and compares each response
// against ~stimulus in a one-deep compare stage. It keeps pass and fail
// counters for the run and latches the index and difference pattern of the
// first mismatch. Every output is a register, except in_ready, which is
// decoded from registers only.

module not16_resp_checker #(
    parameter int WIDTH   = 16,
    parameter int CNT_W   = 8,
    parameter int NUM_VEC = 5   // legal range 1 .. 2**CNT_W-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_stim,
    input  logic [WIDTH-1:0] in_resp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_diff
);

    localparam logic [CNT_W-1:0] NUM_VEC_C = CNT_W'(NUM_VEC);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_VEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // One accepted pair, waiting one cycle to be scored.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] stim;
        logic [WIDTH-1:0] resp;
        logic [CNT_W-1:0] idx;
    } cmp_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] acc_idx_q, acc_idx_d;
    cmp_t             cmp_q, cmp_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH-1:0] ff_diff_q, ff_diff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             ready;
    logic             accept;
    logic [WIDTH-1:0] cmp_diff;

    // Ready is decoded from registers alone, so it never waits on in_valid.
    assign ready    = (state_q == S_RUN) && (acc_idx_q < NUM_VEC_C);
    assign accept   = in_valid && ready;
    // Any set bit marks a response bit that failed to invert.
    assign cmp_diff = cmp_q.resp ^ ~cmp_q.stim;

    // Next-state logic for the run FSM, the accept stage and the scoreboard.
    always_comb begin
        // NOTE: every _d starts as its _q, so any path that does not assign
        // it holds state instead of inferring a latch.
        state_d   = state_q;
        acc_idx_d = acc_idx_q;
        cmp_d     = cmp_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        err_d     = err_q;
        ff_idx_d  = ff_idx_q;
        ff_diff_d = ff_diff_q;
        busy_d    = busy_q;
        done_d    = done_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // A new run wipes every result of the previous one.
                if (start) begin
                    state_d    = S_RUN;
                    acc_idx_d  = '0;
                    cmp_d      = '0;
                    pass_cnt_d = '0;
                    fail_cnt_d = '0;
                    err_d      = 1'b0;
                    ff_idx_d   = '0;
                    ff_diff_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end

            S_RUN: begin
                // Accept stage: capture the pair and its index, then advance.
                cmp_d.vld = accept;
                if (accept) begin
                    cmp_d.stim = in_stim;
                    cmp_d.resp = in_resp;
                    cmp_d.idx  = acc_idx_q;
                    acc_idx_d  = acc_idx_q + CNT_W'(1);
                end

                // Compare stage: score the pair accepted on the previous edge.
                if (cmp_q.vld) begin
                    if (cmp_diff == '0) begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end else begin
                        fail_cnt_d = fail_cnt_q + CNT_W'(1);
                        if (!err_q) begin
                            err_d     = 1'b1;
                            ff_idx_d  = cmp_q.idx;
                            ff_diff_d = cmp_diff;
                        end
                    end
                    if (cmp_q.idx == LAST_IDX) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts a run and discards any in-flight pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_idx_q  <= '0;
            cmp_q      <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            err_q      <= 1'b0;
            ff_idx_q   <= '0;
            ff_diff_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            acc_idx_q  <= acc_idx_d;
            cmp_q      <= cmp_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            err_q      <= err_d;
            ff_idx_q   <= ff_idx_d;
            ff_diff_q  <= ff_diff_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready        = ready;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass_cnt        = pass_cnt_q;
    assign fail_cnt        = fail_cnt_q;
    assign err             = err_q;
    assign first_fail_idx  = ff_idx_q;
    assign first_fail_diff = ff_diff_q;

endmodule
